rom_burst_reader: RTL and testbench
===================================

ROM_BURST_READER -- requirements
Module: rom_burst_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, address width (ROM depth 2^ADDR_W).
REQ-002 SHALL have parameter DATA_W, default 8, ROM word width.
REQ-003 SHALL have parameter LATENCY, default 1, ROM read pipeline stages, legal values 1..3.
REQ-004 SHALL have port clock  input  1  rising-edge clock.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port cmd_valid  input  1  burst command offered.
REQ-007 SHALL have port cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high at a clock edge.
REQ-008 SHALL have port cmd_addr  input  ADDR_W  burst start address.
REQ-009 SHALL have port cmd_len  input  ADDR_W  beats minus one (0 = 1 beat).
REQ-010 SHALL have port cmd_wrap  input  1  1 = address wraps modulo 2^ADDR_W; 0 = burst truncates at address 2^ADDR_W-1.
REQ-011 SHALL have port out_valid  output  1  out_data/out_addr/out_last valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts beat on out_valid and out_ready at a clock edge.
REQ-013 SHALL have port out_data  output  DATA_W  ROM word.
REQ-014 SHALL have port out_addr  output  ADDR_W  address of out_data.
REQ-015 SHALL have port out_last  output  1  final beat of current burst.
REQ-016 SHALL have port busy  output  1  high from command acceptance until last beat is accepted.

Function
REQ-017 ROM word at address a SHALL be (3*a + 1) mod 2^DATA_W; contents fixed, no write port.
REQ-018 State machine SHALL have states IDLE, ISSUE, DRAIN; cmd_ready SHALL be high only in IDLE.
REQ-019 IDLE -> ISSUE on command acceptance; start address, remaining count and wrap mode latched at that edge.
REQ-020 In ISSUE one ROM read SHALL be issued per cycle when output buffer credit is available, address incrementing by 1.
REQ-021 cmd_wrap=1: increment modulo 2^ADDR_W; burst length always cmd_len+1 beats.
REQ-022 cmd_wrap=0: burst SHALL end at min(cmd_addr+cmd_len, 2^ADDR_W-1); no beat beyond top address.
REQ-023 ISSUE -> DRAIN after the last read is issued; DRAIN -> IDLE on the edge the out_last beat is accepted.
REQ-024 Read data SHALL appear at the output buffer exactly LATENCY cycles after issue.
REQ-025 Output buffer SHALL be a FIFO of depth LATENCY+1; reads issued only if occupancy plus in-flight reads < LATENCY+1, so no beat is ever dropped under any out_ready pattern.
REQ-026 out_data/out_addr/out_last SHALL remain stable while out_valid is high and out_ready is low.
REQ-027 With out_ready held high, throughput SHALL be one beat per cycle; first beat out_valid LATENCY+1 cycles after command acceptance.
REQ-028 out_last SHALL be high on exactly one beat per burst.
REQ-029 cmd_valid while not in IDLE SHALL be ignored (not accepted, no side effect).
REQ-030 Simultaneous FIFO push and pop at full SHALL be legal and keep occupancy unchanged.

Reset
REQ-031 Reset SHALL take priority over all events, including mid-burst, and return state to IDLE.
REQ-032 Reset values: cmd_ready=1 after reset release, out_valid=0, out_last=0, busy=0, out_data=0, out_addr=0, FIFO empty, in-flight reads discarded.
REQ-033 First command SHALL be accepted on the first edge after reset deasserts.

Verification
REQ-034 Burst addr=0, len=3, wrap=1, out_ready=1, LATENCY=1 -> beats (addr,data) (0,01),(1,04),(2,07),(3,0A); out_last on 4th; first out_valid 2 cycles after acceptance.
REQ-035 Burst addr=62, len=3, wrap=1 -> addrs 3E,3F,00,01, data BB,BE,01,04.
REQ-036 Burst addr=62, len=3, wrap=0 -> 2 beats only, addrs 3E,3F, out_last on 3F, then IDLE.
REQ-037 addr=10, len=15, out_ready toggling 1-0 each cycle, LATENCY=3 -> all 16 beats data 1F..4C in order, none duplicated or lost, FIFO never exceeds 4 entries.
REQ-038 Reset asserted 3 cycles into len=15 burst -> next cycle out_valid=0, busy=0; new command addr=5, len=0 -> single beat (05,10) with out_last=1.
REQ-039 cmd_valid held high through a burst -> exactly one acceptance per IDLE period; cmd_ready low while busy=1.

Source files
------------

// File: rtl/rom_burst_reader_if.sv
// Command and beat-output handshake bundle for rom_burst_reader.
// The slave modport is the reader side; the master modport is the requester/consumer side.
interface rom_burst_reader_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W-1:0] cmd_len;
    logic              cmd_wrap;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              out_last;

    modport master (
        output cmd_valid, cmd_addr, cmd_len, cmd_wrap, out_ready,
        input  cmd_ready, out_valid, out_data, out_addr, out_last
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_len, cmd_wrap, out_ready,
        output cmd_ready, out_valid, out_data, out_addr, out_last
    );
endinterface

// File: rtl/rom_burst_reader.sv
// Burst reader over a fixed ROM (word = 3*a+1) with a LATENCY-stage read pipe
// feeding a credit-controlled output FIFO of depth LATENCY+1.
module rom_burst_reader #(
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 8,
    parameter int LATENCY = 1
) (
    input  logic                clock,
    input  logic                reset,
    rom_burst_reader_if.slave   bus,
    output logic                busy
);
    localparam int DEPTH = LATENCY + 1;
    localparam int PTR_W = 2;
    localparam int SLOTS = 4;

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2} state_t;

    function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
        return DATA_W'(32'(a) * 32'd3 + 32'd1);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + 2'd1;
        end
    endfunction

    state_t            state_r, state_s;
    logic [ADDR_W-1:0] addr_r, rem_r, len_eff_s;
    logic [ADDR_W:0]   end_sum_s;
    logic              accept_s, issue_s, push_s, pop_s, credit_s;
    logic [3:0]        inflight_s, total_s;

    logic              pipe_valid_r [LATENCY];
    logic [ADDR_W-1:0] pipe_addr_r  [LATENCY];
    logic [DATA_W-1:0] pipe_data_r  [LATENCY];
    logic              pipe_last_r  [LATENCY];

    logic [ADDR_W-1:0] fifo_addr_r [SLOTS];
    logic [DATA_W-1:0] fifo_data_r [SLOTS];
    logic              fifo_last_r [SLOTS];
    logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
    logic [2:0]        count_r;

    assign accept_s      = (state_r == IDLE) && bus.cmd_valid;
    assign pop_s         = (count_r != 3'd0) && bus.out_ready;
    assign push_s        = pipe_valid_r[LATENCY-1];
    assign bus.cmd_ready = (state_r == IDLE);
    assign busy          = (state_r != IDLE);
    assign bus.out_valid = (count_r != 3'd0);
    assign bus.out_data  = fifo_data_r[rd_ptr_r];
    assign bus.out_addr  = fifo_addr_r[rd_ptr_r];
    assign bus.out_last  = fifo_last_r[rd_ptr_r];

    // Non-wrapping bursts are clipped so the final beat is the top address.
    always_comb begin
        end_sum_s = {1'b0, bus.cmd_addr} + {1'b0, bus.cmd_len};
        if (!bus.cmd_wrap && end_sum_s[ADDR_W]) begin
            len_eff_s = ~bus.cmd_addr;
        end else begin
            len_eff_s = bus.cmd_len;
        end
    end

    // Credit: entries left after this cycle's pop plus reads in flight must stay below DEPTH.
    always_comb begin
        inflight_s = 4'd0;
        for (int i = 0; i < LATENCY; i++) begin
            inflight_s = inflight_s + {3'b000, pipe_valid_r[i]};
        end
        total_s  = {1'b0, count_r} - {3'b000, pop_s} + inflight_s;
        credit_s = (total_s < 4'(DEPTH));
        issue_s  = (state_r == ISSUE) && credit_s;
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_s = ISSUE;
                else          state_s = IDLE;
            end
            ISSUE: begin
                if (issue_s && (rem_r == '0)) state_s = DRAIN;
                else                          state_s = ISSUE;
            end
            DRAIN: begin
                if (pop_s && bus.out_last) state_s = IDLE;
                else                       state_s = DRAIN;
            end
            default: state_s = IDLE;
        endcase
    end

    // Read address and remaining-beat counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_r <= '0;
            rem_r  <= '0;
        end else if (accept_s) begin
            addr_r <= bus.cmd_addr;
            rem_r  <= len_eff_s;
        end else if (issue_s) begin
            addr_r <= addr_r + ADDR_W'(1);
            rem_r  <= rem_r - ADDR_W'(1);
        end else begin
            addr_r <= addr_r;
            rem_r  <= rem_r;
        end
    end

    // ROM read pipeline; reset discards anything in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe_valid_r[i] <= 1'b0;
                pipe_addr_r[i]  <= '0;
                pipe_data_r[i]  <= '0;
                pipe_last_r[i]  <= 1'b0;
            end
        end else begin
            pipe_valid_r[0] <= issue_s;
            pipe_addr_r[0]  <= addr_r;
            pipe_data_r[0]  <= rom_word(addr_r);
            pipe_last_r[0]  <= (rem_r == '0);
            for (int i = 1; i < LATENCY; i++) begin
                pipe_valid_r[i] <= pipe_valid_r[i-1];
                pipe_addr_r[i]  <= pipe_addr_r[i-1];
                pipe_data_r[i]  <= pipe_data_r[i-1];
                pipe_last_r[i]  <= pipe_last_r[i-1];
            end
        end
    end

    // Output FIFO; push and pop together at full leave occupancy unchanged.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= 3'd0;
            for (int i = 0; i < SLOTS; i++) begin
                fifo_addr_r[i] <= '0;
                fifo_data_r[i] <= '0;
                fifo_last_r[i] <= 1'b0;
            end
        end else begin
            if (push_s) begin
                fifo_addr_r[wr_ptr_r] <= pipe_addr_r[LATENCY-1];
                fifo_data_r[wr_ptr_r] <= pipe_data_r[LATENCY-1];
                fifo_last_r[wr_ptr_r] <= pipe_last_r[LATENCY-1];
                wr_ptr_r              <= ptr_next(wr_ptr_r);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_next(rd_ptr_r);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            count_r <= count_r + {2'b00, push_s} - {2'b00, pop_s};
        end
    end
endmodule

// File: tb/tb_rom_burst_reader.sv
// Drives a LATENCY=1 and a LATENCY=3 reader with identical commands and checks
// every beat against a burst model computed from plain address arithmetic.
module tb_rom_burst_reader;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_wrap = 1'b0;
    logic       out_ready = 1'b0;
    logic [5:0] cmd_addr = 6'd0;
    logic [5:0] cmd_len = 6'd0;

    logic       ov [2];
    logic       ol [2];
    logic       bsy [2];
    logic       crdy [2];
    logic [5:0] oa [2];
    logic [7:0] od [2];

    int checks = 0;
    int errors = 0;
    int lat [2] = '{1, 3};

    rom_burst_reader_if #(.ADDR_W(6), .DATA_W(8)) bif0 ();
    rom_burst_reader_if #(.ADDR_W(6), .DATA_W(8)) bif1 ();

    assign bif0.cmd_valid = cmd_valid;
    assign bif0.cmd_addr  = cmd_addr;
    assign bif0.cmd_len   = cmd_len;
    assign bif0.cmd_wrap  = cmd_wrap;
    assign bif0.out_ready = out_ready;
    assign bif1.cmd_valid = cmd_valid;
    assign bif1.cmd_addr  = cmd_addr;
    assign bif1.cmd_len   = cmd_len;
    assign bif1.cmd_wrap  = cmd_wrap;
    assign bif1.out_ready = out_ready;

    assign ov[0] = bif0.out_valid;  assign ov[1] = bif1.out_valid;
    assign ol[0] = bif0.out_last;   assign ol[1] = bif1.out_last;
    assign oa[0] = bif0.out_addr;   assign oa[1] = bif1.out_addr;
    assign od[0] = bif0.out_data;   assign od[1] = bif1.out_data;
    assign crdy[0] = bif0.cmd_ready; assign crdy[1] = bif1.cmd_ready;

    rom_burst_reader #(.ADDR_W(6), .DATA_W(8), .LATENCY(1)) dut0 (
        .clock(clock), .reset(reset), .bus(bif0), .busy(bsy[0])
    );
    rom_burst_reader #(.ADDR_W(6), .DATA_W(8), .LATENCY(3)) dut1 (
        .clock(clock), .reset(reset), .bus(bif1), .busy(bsy[1])
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge with both readers idle; returns at the negedge after acceptance.
    task automatic send_cmd(input int a, input int l, input int w, input int hold);
        cmd_addr  = 6'(a);
        cmd_len   = 6'(l);
        cmd_wrap  = (w != 0);
        cmd_valid = 1'b1;
        for (int d = 0; d < 2; d++) chk($sformatf("cmd_ready_idle%0d", d), int'(crdy[d]), 1);
        @(posedge clock);
        @(negedge clock);
        cmd_valid = (hold != 0);
        for (int d = 0; d < 2; d++) chk($sformatf("busy_after_accept%0d", d), int'(bsy[d]), 1);
    endtask

    // mode 0: out_ready high, 1: toggling starting high, 2: random.
    task automatic collect(input int a, input int l, input int w, input int mode, input int hold);
        int n, k, ea, viol, extra, cur;
        int idx [2];
        int first_k [2];
        int last_k [2];
        int sav [2];
        logic stall [2];
        if (w != 0 || a + l <= 63) n = l + 1;
        else                       n = 64 - a;
        idx = '{0, 0}; first_k = '{-1, -1}; last_k = '{-1, -1};
        sav = '{0, 0}; stall = '{1'b0, 1'b0};
        viol = 0; extra = 0; k = 1;
        while ((idx[0] < n || idx[1] < n) && k < 600) begin
            if (hold != 0) cmd_valid = (idx[0] < n) && (idx[1] < n);
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (k % 2 == 1);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            for (int d = 0; d < 2; d++) begin
                if (crdy[d] && cmd_valid) extra++;
                if (bsy[d] && crdy[d]) viol++;
                cur = int'({ov[d], ol[d], oa[d], od[d]});
                if (stall[d]) chk($sformatf("stable%0d", d), cur, sav[d]);
                stall[d] = ov[d] && !out_ready;
                sav[d] = cur;
                if (ov[d] && first_k[d] < 0) first_k[d] = k;
                if (ov[d] && out_ready) begin
                    if (idx[d] < n) begin
                        ea = (a + idx[d]) % 64;
                        chk($sformatf("addr%0d", d), int'(oa[d]), ea);
                        chk($sformatf("data%0d", d), int'(od[d]), (3 * ea + 1) % 256);
                        chk($sformatf("last%0d", d), int'(ol[d]), (idx[d] == n - 1) ? 1 : 0);
                        idx[d]++;
                        last_k[d] = k;
                    end else begin
                        chk($sformatf("extra_beat%0d", d), int'(ov[d]), 0);
                    end
                end
            end
            @(posedge clock);
            @(negedge clock);
            k++;
        end
        cmd_valid = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("beats%0d", d), idx[d], n);
            chk($sformatf("first_valid%0d", d), first_k[d], lat[d] + 2);
            if (mode == 0) chk($sformatf("throughput%0d", d), last_k[d] - first_k[d], n - 1);
            chk($sformatf("end_busy%0d", d), int'(bsy[d]), 0);
            chk($sformatf("end_ready%0d", d), int'(crdy[d]), 1);
            chk($sformatf("end_valid%0d", d), int'(ov[d]), 0);
        end
        chk("ready_while_busy", viol, 0);
        if (hold != 0) chk("reaccept", extra, 0);
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_valid%0d", d), int'(ov[d]), 0);
            chk($sformatf("rst_last%0d", d), int'(ol[d]), 0);
            chk($sformatf("rst_data%0d", d), int'(od[d]), 0);
            chk($sformatf("rst_addr%0d", d), int'(oa[d]), 0);
            chk($sformatf("rst_busy%0d", d), int'(bsy[d]), 0);
        end
        reset = 1'b0;

        send_cmd(0, 3, 1, 0);
        collect(0, 3, 1, 0, 0);
        send_cmd(62, 3, 1, 0);
        collect(62, 3, 1, 0, 0);
        send_cmd(62, 3, 0, 0);
        collect(62, 3, 0, 0, 0);
        send_cmd(10, 15, 1, 0);
        collect(10, 15, 1, 1, 0);
        send_cmd(20, 7, 1, 1);
        collect(20, 7, 1, 0, 1);

        // Reset three cycles into a long burst.
        send_cmd(0, 15, 1, 0);
        out_ready = 1'b1;
        repeat (3) begin
            @(posedge clock);
            @(negedge clock);
        end
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("midrst_valid%0d", d), int'(ov[d]), 0);
            chk($sformatf("midrst_busy%0d", d), int'(bsy[d]), 0);
        end
        reset = 1'b0;
        send_cmd(5, 0, 1, 0);
        collect(5, 0, 1, 0, 0);

        for (int i = 0; i < 12; i++) begin
            int a, l, w;
            a = int'($urandom_range(0, 63));
            l = int'($urandom_range(0, 63));
            w = int'($urandom_range(0, 1));
            send_cmd(a, l, w, 0);
            collect(a, l, w, 2, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
